regbank_wb_ctrl: RTL and testbench

- Write-back side controller that drives the register bank's write port (writeBack, we, we_high, read_mem, addr_d, data_d, mem_q).
- Accepts one retiring instruction at a time from execute and waits for memory data on loads.
- Presents exactly one single-cycle commit pulse to the register bank per write.
- Supplies forwarding and hazard information to the read stage for in-flight writes.

---
 rtl/regbank_wb_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_regbank_wb_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wb_ctrl.sv
// Write-back controller: holds one retiring instruction, waits for load data,
// issues a single-cycle commit to the register bank and drives forwarding/hazard info.
module regbank_wb_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [3:0]       ex_addr_d,
    input  logic [31:0]      ex_data,
    input  logic             ex_we,
    input  logic             ex_we_high,
    input  logic             ex_read_mem,

    input  logic             mem_done,
    input  logic [31:0]      mem_q,

    output logic             rb_writeBack,
    output logic             rb_we,
    output logic             rb_we_high,
    output logic             rb_read_mem,
    output logic [3:0]       rb_addr_d,
    output logic [31:0]      rb_data_d,
    output logic [31:0]      rb_mem_q,

    input  logic [3:0]       rd_addr_a,
    input  logic [3:0]       rd_addr_b,
    output logic             fwd_hit_a,
    output logic             fwd_hit_b,
    output logic [31:0]      fwd_data_a,
    output logic [31:0]      fwd_data_b,
    output logic             hazard,

    output logic             timeout_err,
    output logic [CNT_W-1:0] commit_cnt
);

    localparam int                WCNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_MEM = 2'd1;
    localparam logic [1:0] S_COMMIT   = 2'd2;

    typedef struct packed {
        logic        hit;
        logic        stall;
        logic [31:0] data;
    } fwd_t;

    logic [1:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic [3:0]        pend_addr_q, pend_addr_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic              pend_we_high_q, pend_we_high_d;
    logic              pend_read_mem_q, pend_read_mem_d;

    logic              cm_we_q, cm_we_d;
    logic              cm_we_high_q, cm_we_high_d;
    logic              cm_read_mem_q, cm_read_mem_d;
    logic [3:0]        cm_addr_q, cm_addr_d;
    logic [31:0]       cm_data_q, cm_data_d;
    logic [31:0]       mem_cap_q, mem_cap_d;

    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              enter_commit;
    fwd_t              fwd_a, fwd_b;

    assign accept = ex_valid && (state_q == S_IDLE);

    // Control FSM, wait counter, load-data capture and sticky timeout flag.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_cap_d = mem_cap_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (accept && ex_we) begin
                    if (ex_read_mem) begin
                        state_d = S_WAIT_MEM;
                        wcnt_d  = '0;
                    end else begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (mem_done) begin
                    state_d   = S_COMMIT;
                    mem_cap_d = mem_q;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Pending entry: latched on an accepted register-writing instruction.
    always_comb begin
        pend_addr_d     = pend_addr_q;
        pend_data_d     = pend_data_q;
        pend_we_high_d  = pend_we_high_q;
        pend_read_mem_d = pend_read_mem_q;
        if (accept && ex_we) begin
            pend_addr_d     = ex_addr_d;
            pend_data_d     = ex_data;
            // A load always writes the full word, so a half-write request is dropped.
            pend_we_high_d  = ex_we_high && !ex_read_mem;
            pend_read_mem_d = ex_read_mem;
        end
    end

    // Commit-side outputs load on entry to COMMIT and hold afterwards.
    // From IDLE the pending registers are being written on the same edge,
    // so the values come straight from execute.
    assign enter_commit = (state_d == S_COMMIT) && (state_q != S_COMMIT);

    always_comb begin
        cm_we_d       = cm_we_q;
        cm_we_high_d  = cm_we_high_q;
        cm_read_mem_d = cm_read_mem_q;
        cm_addr_d     = cm_addr_q;
        cm_data_d     = cm_data_q;
        if (enter_commit) begin
            if (state_q == S_IDLE) begin
                cm_we_d       = (ex_addr_d != 4'd0);
                cm_we_high_d  = ex_we_high && !ex_read_mem;
                cm_read_mem_d = ex_read_mem;
                cm_addr_d     = ex_addr_d;
                cm_data_d     = ex_data;
            end else begin
                cm_we_d       = (pend_addr_q != 4'd0);
                cm_we_high_d  = pend_we_high_q;
                cm_read_mem_d = pend_read_mem_q;
                cm_addr_d     = pend_addr_q;
                cm_data_d     = pend_data_q;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_COMMIT) && cm_we_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: the datapath registers are reset too, so rb_* and fwd_* read zero after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            wcnt_q          <= '0;
            pend_addr_q     <= '0;
            pend_data_q     <= '0;
            pend_we_high_q  <= 1'b0;
            pend_read_mem_q <= 1'b0;
            cm_we_q         <= 1'b0;
            cm_we_high_q    <= 1'b0;
            cm_read_mem_q   <= 1'b0;
            cm_addr_q       <= '0;
            cm_data_q       <= '0;
            mem_cap_q       <= '0;
            timeout_q       <= 1'b0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            wcnt_q          <= wcnt_d;
            pend_addr_q     <= pend_addr_d;
            pend_data_q     <= pend_data_d;
            pend_we_high_q  <= pend_we_high_d;
            pend_read_mem_q <= pend_read_mem_d;
            cm_we_q         <= cm_we_d;
            cm_we_high_q    <= cm_we_high_d;
            cm_read_mem_q   <= cm_read_mem_d;
            cm_addr_q       <= cm_addr_d;
            cm_data_q       <= cm_data_d;
            mem_cap_q       <= mem_cap_d;
            timeout_q       <= timeout_d;
            cnt_q           <= cnt_d;
        end
    end

    // Forwarding is only safe for a full-word write in its commit cycle; anything
    // else that matches a read address must stall the read stage.
    function automatic fwd_t fwd_lookup(
        input logic [3:0]  rd,
        input logic [1:0]  state,
        input logic [3:0]  p_addr,
        input logic [31:0] p_data,
        input logic        p_we_high,
        input logic        p_read_mem,
        input logic [31:0] m_data
    );
        fwd_t r;
        r = '0;
        if ((state != S_IDLE) && (rd == p_addr) && (rd != 4'd0)) begin
            if ((state == S_COMMIT) && !p_we_high) begin
                r.hit  = 1'b1;
                r.data = p_read_mem ? m_data : p_data;
            end else begin
                r.stall = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        fwd_a = fwd_lookup(rd_addr_a, state_q, pend_addr_q, pend_data_q,
                           pend_we_high_q, pend_read_mem_q, mem_cap_q);
        fwd_b = fwd_lookup(rd_addr_b, state_q, pend_addr_q, pend_data_q,
                           pend_we_high_q, pend_read_mem_q, mem_cap_q);
    end

    assign ex_ready     = (state_q == S_IDLE);
    assign rb_writeBack = (state_q == S_COMMIT);
    assign rb_we        = cm_we_q;
    assign rb_we_high   = cm_we_high_q;
    assign rb_read_mem  = cm_read_mem_q;
    assign rb_addr_d    = cm_addr_q;
    assign rb_data_d    = cm_data_q;
    assign rb_mem_q     = mem_cap_q;
    assign fwd_hit_a    = fwd_a.hit;
    assign fwd_hit_b    = fwd_b.hit;
    assign fwd_data_a   = fwd_a.data;
    assign fwd_data_b   = fwd_b.data;
    assign hazard       = fwd_a.stall || fwd_b.stall;
    assign timeout_err  = timeout_q;
    assign commit_cnt   = cnt_q;

endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// Scoreboard bench for regbank_wb_ctrl: directed scenarios plus random traffic
// checked against a transaction-level model of the write-back stage.
module tb_regbank_wb_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             ex_valid = 1'b0;
    logic             ex_ready;
    logic [3:0]       ex_addr_d = '0;
    logic [31:0]      ex_data = '0;
    logic             ex_we = 1'b0;
    logic             ex_we_high = 1'b0;
    logic             ex_read_mem = 1'b0;
    logic             mem_done = 1'b0;
    logic [31:0]      mem_q = '0;
    logic             rb_writeBack, rb_we, rb_we_high, rb_read_mem;
    logic [3:0]       rb_addr_d;
    logic [31:0]      rb_data_d, rb_mem_q;
    logic [3:0]       rd_addr_a = '0;
    logic [3:0]       rd_addr_b = '0;
    logic             fwd_hit_a, fwd_hit_b;
    logic [31:0]      fwd_data_a, fwd_data_b;
    logic             hazard;
    logic             timeout_err;
    logic [CNT_W-1:0] commit_cnt;

    regbank_wb_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr_d(ex_addr_d), .ex_data(ex_data),
        .ex_we(ex_we), .ex_we_high(ex_we_high), .ex_read_mem(ex_read_mem),
        .mem_done(mem_done), .mem_q(mem_q),
        .rb_writeBack(rb_writeBack), .rb_we(rb_we), .rb_we_high(rb_we_high),
        .rb_read_mem(rb_read_mem), .rb_addr_d(rb_addr_d), .rb_data_d(rb_data_d),
        .rb_mem_q(rb_mem_q),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .hazard(hazard), .timeout_err(timeout_err), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        we_high;
        logic        read_mem;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] mem_q;
    } commit_t;

    commit_t exp_q[$];
    commit_t mon_e;

    // Model of the stage: phase 0 = no instruction held, 1 = waiting for load data,
    // 2 = commit cycle. Updated by the stimulus just after each rising edge.
    int          m_phase   = 0;
    logic [3:0]  m_addr    = '0;
    logic [31:0] m_data    = '0;
    logic [31:0] m_mem     = '0;
    logic        m_wh      = 1'b0;
    logic        m_rm      = 1'b0;
    logic        m_timeout = 1'b0;
    int          m_cnt     = 0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void exp_fwd(input logic [3:0] rd, output logic hit,
                                    output logic [31:0] data, output logic stall);
        hit = 1'b0;
        data = '0;
        stall = 1'b0;
        if (m_phase != 0 && rd == m_addr && rd != 4'd0) begin
            if (m_phase == 2 && !m_wh) begin
                hit  = 1'b1;
                data = m_rm ? m_mem : m_data;
            end else begin
                stall = 1'b1;
            end
        end
    endfunction

    // Monitor: compares every cycle on the falling edge, pops one expected commit
    // per commit cycle.
    always @(negedge clk) begin
        logic        ha, hb, sa, sb;
        logic [31:0] da, db;
        check("rb_writeBack", rb_writeBack, m_phase == 2);
        if (m_phase == 2) begin
            if (exp_q.size() == 0) begin
                check("commit_expected", rb_writeBack, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rb_we", rb_we, mon_e.we);
                check("rb_we_high", rb_we_high, mon_e.we_high);
                check("rb_read_mem", rb_read_mem, mon_e.read_mem);
                check("rb_addr_d", rb_addr_d, mon_e.addr);
                check("rb_data_d", rb_data_d, mon_e.data);
                check("rb_mem_q", rb_mem_q, mon_e.mem_q);
            end
        end
        check("ex_ready", ex_ready, m_phase == 0);
        check("timeout_err", timeout_err, m_timeout);
        check("commit_cnt", commit_cnt, 32'(m_cnt % (1 << CNT_W)));
        exp_fwd(rd_addr_a, ha, da, sa);
        exp_fwd(rd_addr_b, hb, db, sb);
        check("fwd_hit_a", fwd_hit_a, ha);
        check("fwd_data_a", fwd_data_a, da);
        check("fwd_hit_b", fwd_hit_b, hb);
        check("fwd_data_b", fwd_data_b, db);
        check("hazard", hazard, sa || sb);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rd(input int rda, input int rdb);
        rd_addr_a = (rda >= 0) ? 4'(rda) : ($urandom_range(0, 1) != 0 ? m_addr : 4'($urandom_range(0, 15)));
        rd_addr_b = (rdb >= 0) ? 4'(rdb) : ($urandom_range(0, 1) != 0 ? m_addr : 4'($urandom_range(0, 15)));
    endtask

    // Inputs offered while the stage is busy; the DUT must ignore all of them.
    task automatic drive_junk();
        ex_valid    = 1'($urandom_range(0, 1));
        ex_addr_d   = 4'($urandom_range(0, 15));
        ex_data     = $urandom;
        ex_we       = 1'($urandom_range(0, 1));
        ex_we_high  = 1'($urandom_range(0, 1));
        ex_read_mem = 1'($urandom_range(0, 1));
        mem_done    = 1'($urandom_range(0, 1));
        mem_q       = $urandom;
    endtask

    task automatic idle_cycle();
        ex_valid = 1'b0;
        mem_done = 1'($urandom_range(0, 1));
        mem_q    = $urandom;
        drive_rd(-1, -1);
        step();
    endtask

    // Offers one instruction in an idle cycle and follows it to completion.
    // delay = index of the wait cycle carrying mem_done; delay >= TIMEOUT never delivers.
    task automatic issue(input logic [3:0] a, input logic [31:0] d, input logic we,
                         input logic wh, input logic rm, input int delay,
                         input logic [31:0] mv, input int rda, input int rdb);
        commit_t e;
        logic    done;
        ex_valid    = 1'b1;
        ex_addr_d   = a;
        ex_data     = d;
        ex_we       = we;
        ex_we_high  = wh;
        ex_read_mem = rm;
        mem_done    = 1'($urandom_range(0, 1));
        mem_q       = $urandom;
        drive_rd(rda, rdb);
        step();
        if (!we) begin
            ex_valid = 1'b0;
            return;
        end
        m_addr = a;
        m_data = d;
        m_wh   = wh && !rm;
        m_rm   = rm;
        if (rm) begin
            m_phase = 1;
            done = 1'b0;
            for (int i = 0; i < TIMEOUT; i++) begin
                drive_junk();
                drive_rd(rda, rdb);
                if (i == delay) begin
                    mem_done = 1'b1;
                    mem_q    = mv;
                end else begin
                    mem_done = 1'b0;
                end
                step();
                if (i == delay) begin
                    done  = 1'b1;
                    m_mem = mv;
                    break;
                end
            end
            if (!done) begin
                m_phase   = 0;
                m_timeout = 1'b1;
                ex_valid  = 1'b0;
                return;
            end
        end
        m_phase    = 2;
        e.we       = (a != 4'd0);
        e.we_high  = m_wh;
        e.read_mem = rm;
        e.addr     = a;
        e.data     = d;
        e.mem_q    = m_mem;
        exp_q.push_back(e);
        drive_junk();
        drive_rd(rda, rdb);
        step();
        m_phase  = 0;
        if (a != 4'd0) m_cnt++;
        ex_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_rb_writeBack", rb_writeBack, 1'b0);
        check("rst_rb_we", rb_we, 1'b0);
        check("rst_rb_we_high", rb_we_high, 1'b0);
        check("rst_rb_read_mem", rb_read_mem, 1'b0);
        check("rst_rb_addr_d", rb_addr_d, 4'd0);
        check("rst_rb_data_d", rb_data_d, 32'd0);
        check("rst_rb_mem_q", rb_mem_q, 32'd0);
        check("rst_fwd_hit_a", fwd_hit_a, 1'b0);
        check("rst_fwd_hit_b", fwd_hit_b, 1'b0);
        check("rst_fwd_data_a", fwd_data_a, 32'd0);
        check("rst_fwd_data_b", fwd_data_b, 32'd0);
        check("rst_hazard", hazard, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_commit_cnt", commit_cnt, 32'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs();
        step();
        step();
        reset = 1'b1;
        step();
        check("ready_after_reset", ex_ready, 1'b1);

        // ALU write with forwarding on port a.
        issue(4'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 0, 32'h0, 3, -1);
        // Load: data after two wait cycles, then on the final count.
        issue(4'd5, 32'h0BAD0005, 1'b1, 1'b0, 1'b1, 2, 32'h12345678, -1, 5);
        issue(4'd5, 32'h0BAD0006, 1'b1, 1'b0, 1'b1, TIMEOUT - 1, 32'h87654321, -1, 5);
        // Load that never completes, then late mem_done pulses.
        issue(4'd6, 32'h00000066, 1'b1, 1'b0, 1'b1, TIMEOUT, 32'h0, 6, 6);
        mem_done = 1'b1;
        mem_q    = 32'hFEEDFACE;
        ex_valid = 1'b0;
        repeat (3) step();
        // Half write, write to r0, load with we_high, discarded instruction.
        issue(4'd2, 32'h0000ABCD, 1'b1, 1'b1, 1'b0, 0, 32'h0, 2, -1);
        issue(4'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 0, 32'h0, 0, 0);
        issue(4'd9, 32'h00009999, 1'b1, 1'b1, 1'b1, 1, 32'hA5A5A5A5, 9, -1);
        issue(4'd4, 32'h44444444, 1'b0, 1'b0, 1'b0, 0, 32'h0, 4, 4);
        idle_cycle();

        // Reset asserted in the middle of a load wait.
        ex_valid    = 1'b1;
        ex_addr_d   = 4'd7;
        ex_data     = 32'h77777777;
        ex_we       = 1'b1;
        ex_we_high  = 1'b0;
        ex_read_mem = 1'b1;
        mem_done    = 1'b0;
        drive_rd(7, 7);
        step();
        m_phase  = 1;
        m_addr   = 4'd7;
        m_data   = 32'h77777777;
        m_wh     = 1'b0;
        m_rm     = 1'b1;
        ex_valid = 1'b0;
        step();
        step();
        #2;
        reset     = 1'b0;
        m_phase   = 0;
        m_timeout = 1'b0;
        m_cnt     = 0;
        m_mem     = '0;
        mem_done  = 1'b1;
        mem_q     = 32'hCAFEF00D;
        #1;
        check_reset_outputs();
        step();
        step();
        reset = 1'b1;
        step();
        mem_done = 1'b0;
        check_reset_outputs();
        check("ready_after_reset2", ex_ready, 1'b1);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) idle_cycle();
            issue(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                  $urandom_range(0, TIMEOUT), $urandom, -1, -1);
        end
        idle_cycle();
        idle_cycle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
